// File: rtl/rr_req_frontend.sv
// Per-channel command FIFOs feeding a 4-way round-robin arbiter. Requests follow the FIFO
// occupancy. The granted head entry is popped onto one registered, source-tagged output.
module rr_req_frontend #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        wr_en,
    input  logic [DATA_W-1:0] wr_data0,
    input  logic [DATA_W-1:0] wr_data1,
    input  logic [DATA_W-1:0] wr_data2,
    input  logic [DATA_W-1:0] wr_data3,
    output logic [3:0]        wr_full,
    output logic              req0,
    output logic              req1,
    output logic              req2,
    output logic              req3,
    input  logic              gnt0,
    input  logic              gnt1,
    input  logic              gnt2,
    input  logic              gnt3,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_src,
    output logic [3:0]        ovf,
    output logic              gnt_err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [DATA_W-1:0] mem [4][DEPTH];
    logic [PW-1:0]     wr_ptr [4];
    logic [PW-1:0]     rd_ptr [4];
    logic [CW-1:0]     count  [4];
    logic [DATA_W-1:0] wr_data_a [4];

    logic [3:0]        gnt;
    logic [1:0]        sel;
    logic              sel_hit;
    logic              pop_any;
    logic [3:0]        pop;
    logic [3:0]        push;
    logic              multi_gnt;
    logic [DATA_W-1:0] head;

    assign wr_data_a[0] = wr_data0;
    assign wr_data_a[1] = wr_data1;
    assign wr_data_a[2] = wr_data2;
    assign wr_data_a[3] = wr_data3;

    assign gnt = {gnt3, gnt2, gnt1, gnt0};

    assign req0 = (count[0] != '0);
    assign req1 = (count[1] != '0);
    assign req2 = (count[2] != '0);
    assign req3 = (count[3] != '0);

    // Lowest-index grant wins even when the arbiter misbehaves with several grants.
    always_comb begin
        sel     = 2'd0;
        sel_hit = 1'b0;
        for (int n = 3; n >= 0; n--) begin
            if (gnt[n]) begin
                sel     = 2'(n);
                sel_hit = 1'b1;
            end
        end
    end

    // A grant on an empty channel is a stale arbiter grant and is ignored.
    assign pop_any   = !rst && sel_hit && (count[sel] != '0);
    assign pop       = pop_any ? (4'b0001 << sel) : 4'b0000;
    assign multi_gnt = |(gnt & (gnt - 4'd1));
    assign head      = mem[sel][rd_ptr[sel]];

    always_comb begin
        push    = 4'b0000;
        wr_full = 4'b0000;
        for (int n = 0; n < 4; n++) begin
            wr_full[n] = (count[n] == DEPTH_C);
            // A full channel can still accept a push when its head leaves on the same edge.
            push[n]    = !rst && wr_en[n] && (!wr_full[n] || pop[n]);
        end
    end

    always_ff @(posedge clk) begin
        for (int n = 0; n < 4; n++) begin
            if (push[n]) begin
                mem[n][wr_ptr[n]] <= wr_data_a[n];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < 4; n++) begin
                wr_ptr[n] <= '0;
                rd_ptr[n] <= '0;
                count[n]  <= '0;
            end
            ovf       <= 4'b0000;
            gnt_err   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 2'd0;
        end else begin
            for (int n = 0; n < 4; n++) begin
                if (push[n]) begin
                    wr_ptr[n] <= wr_ptr[n] + PTR_ONE;
                end
                if (pop[n]) begin
                    rd_ptr[n] <= rd_ptr[n] + PTR_ONE;
                end
                if (push[n] && !pop[n]) begin
                    count[n] <= count[n] + CNT_ONE;
                end else if (pop[n] && !push[n]) begin
                    count[n] <= count[n] - CNT_ONE;
                end
                if (wr_en[n] && !push[n]) begin
                    ovf[n] <= 1'b1;
                end
            end
            if (multi_gnt) begin
                gnt_err <= 1'b1;
            end
            out_valid <= pop_any;
            if (pop_any) begin
                out_data <= head;
                out_src  <= sel;
            end
        end
    end

endmodule
